forward_engine: RTL and testbench
=================================

// Module: forward_engine
// PURPOSE
// Forwarding-decision stage between the ingress parser and the per-port egress writers.
// Buffers frame descriptors (buffer start pointer, DA, SA, ingress port) in a small FIFO.
// For each descriptor it learns the SA, looks up the DA, and builds an egress port mask.
// It then issues per-port write requests, holds each until acked, and reports fanout for buffer refcounting.
// PARAMETERS
// NUM_PORTS       4                 switch port count, >=2
// PTR_W           mem_pkg::ADDR_W   buffer start-pointer width
// FIFO_DEPTH      4                 descriptor FIFO entries, power of 2, >=2
// LOOKUP_TIMEOUT  8                 cycles to wait for lookup_valid_i before treating the lookup as a miss
// PORTS (PW = $clog2(NUM_PORTS))
// clk             in   1            clock
// rst             in   1            synchronous, active-high reset
// desc_valid_i    in   1            descriptor valid
// desc_ready_o    out  1            descriptor accept (= !fifo_full)
// start_ptr_i     in   PTR_W        frame start pointer in buffer memory
// dest_addr_i     in   48           destination MAC; first octet in [47:40]
// src_addr_i      in   48           source MAC
// src_port_i      in   PW           ingress port
// learn_en_o      out  1            1-cycle learn pulse to the address table
// learn_addr_o    out  48           SA to learn
// learn_port_o    out  PW           port to associate with the SA
// lookup_req_o    out  1            1-cycle lookup request
// lookup_addr_o   out  48           DA to look up
// lookup_valid_i  in   1            lookup response valid
// lookup_hit_i    in   1            DA is present in the table
// lookup_port_i   in   PW           port for a hit
// write_reqs_o    out  NUM_PORTS    per-port egress write request
// start_ptr_o     out  PTR_W        pointer for the active write_reqs_o
// write_ack_i     in   NUM_PORTS    per-port accept
// fanout_valid_o  out  1            1-cycle pulse: decision made
// fanout_o        out  PW+1         number of egress copies (popcount of mask)
// flood_cnt_o     out  16           floods performed, saturating
// filter_cnt_o    out  16           frames filtered, saturating
// BEHAVIOUR
// - All outputs are registered. Reset: FIFO empty, state IDLE, every output 0 (desc_ready_o=1 after reset).
// - FIFO: push on desc_valid_i&desc_ready_o; no push when full, even if a pop occurs the same cycle.
//   Pop occurs only in IDLE and only when the FIFO is non-empty.
// - Group DA (dest_addr[40]=1, includes broadcast): flood with no lookup.
//   SA with bit 40 set: no learn.
// - FSM IDLE->LOOKUP->DISPATCH->IDLE. For a group DA: IDLE->DISPATCH.
//   Filter case: LOOKUP->IDLE.
// - IDLE, pop at cycle t: working registers are loaded.
//   At t+1: learn_en_o pulses (unless SA is a group address) and lookup_req_o pulses (unicast DA only).
// - LOOKUP: lookup_valid_i is sampled from the cycle after lookup_req_o. A 1-cycle timer runs.
//   After LOOKUP_TIMEOUT cycles with no lookup_valid_i, the descriptor is treated as a miss.
//   lookup_valid_i is ignored in every other state.
// - Mask rules, where flood = all ones & ~(1<<src_port):
//   miss, timeout or group DA -> flood;
//   hit && lookup_port != src_port -> one-hot(lookup_port);
//   hit && lookup_port == src_port -> filter (no writes, filter_cnt++).
// - Decision at cycle d: at d+1, fanout_valid_o pulses and fanout_o = popcount(mask).
//   The filter case pulses with fanout_o=0 and returns to IDLE.
// - DISPATCH: write_reqs_o=mask and start_ptr_o=working pointer from d+1.
//   Bit i clears the cycle after write_ack_i[i]. Acks on bits not requested are ignored.
//   When all bits are clear -> IDLE. The next pop happens the same cycle the FSM is in IDLE.
// - Counters saturate at 16'hFFFF and are cleared only by rst.
// - rst mid-operation: the in-flight descriptor and FIFO contents are discarded.
//   Pending write_reqs_o drop to 0 the next cycle. A late lookup_valid_i is ignored.
// TESTING (NUM_PORTS=4, LOOKUP_TIMEOUT=8)
// 1 Unicast hit: DA=0x0011_2233_4455, src_port=0, hit port=2 -> learn pulse; write_reqs_o=0100;
//   fanout_o=1; bit clears the cycle after write_ack_i[2].
// 2 Broadcast DA=FFFF_FFFF_FFFF, src_port=1 -> no lookup_req_o; write_reqs_o=1101; fanout_o=3;
//   staggered acks clear bits individually; flood_cnt_o=1.
// 3 Timeout: unicast DA, lookup_valid_i never asserts -> flood 1110 (src_port=0) once 8 LOOKUP cycles have elapsed.
// 4 Filter: hit with lookup_port=src_port=3 -> fanout_valid_o with fanout_o=0; no write_reqs_o; filter_cnt_o=1.
// 5 Backpressure: push 5 descriptors with writes stalled -> desc_ready_o=0 after 4 queued (plus 1 active);
//   all 5 are dispatched in order once acked.
// 6 Assert rst during DISPATCH with mask 0110 -> next cycle write_reqs_o=0, desc_ready_o=1;
//   a lookup_valid_i pulse after reset has no effect.

Source files
------------

// File: rtl/mem_pkg.sv
// Buffer-memory parameters shared by the switch datapath.
package mem_pkg;
  localparam int unsigned ADDR_W = 12;
endpackage

// File: rtl/forward_engine.sv
// Forwarding-decision stage: queues frame descriptors, learns the SA, looks up the DA,
// and issues per-port egress write requests while reporting fanout for refcounting.
module forward_engine #(
  parameter int unsigned NUM_PORTS      = 4,
  parameter int unsigned PTR_W          = mem_pkg::ADDR_W,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned LOOKUP_TIMEOUT = 8,
  localparam int unsigned PW            = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 desc_valid_i,
  output logic                 desc_ready_o,
  input  logic [PTR_W-1:0]     start_ptr_i,
  input  logic [47:0]          dest_addr_i,
  input  logic [47:0]          src_addr_i,
  input  logic [PW-1:0]        src_port_i,
  output logic                 learn_en_o,
  output logic [47:0]          learn_addr_o,
  output logic [PW-1:0]        learn_port_o,
  output logic                 lookup_req_o,
  output logic [47:0]          lookup_addr_o,
  input  logic                 lookup_valid_i,
  input  logic                 lookup_hit_i,
  input  logic [PW-1:0]        lookup_port_i,
  output logic [NUM_PORTS-1:0] write_reqs_o,
  output logic [PTR_W-1:0]     start_ptr_o,
  input  logic [NUM_PORTS-1:0] write_ack_i,
  output logic                 fanout_valid_o,
  output logic [PW:0]          fanout_o,
  output logic [15:0]          flood_cnt_o,
  output logic [15:0]          filter_cnt_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned FW = PW + 1;
  localparam int unsigned TW = $clog2(LOOKUP_TIMEOUT + 1);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_DISPATCH} state_e;

  logic [PTR_W-1:0]     fifo_ptr_q  [FIFO_DEPTH];
  logic [47:0]          fifo_da_q   [FIFO_DEPTH];
  logic [47:0]          fifo_sa_q   [FIFO_DEPTH];
  logic [PW-1:0]        fifo_port_q [FIFO_DEPTH];

  state_e               state_q, state_d;
  logic [AW-1:0]        wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [CW-1:0]        count_q, count_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [PTR_W-1:0]     work_ptr_q, work_ptr_d;
  logic [PW-1:0]        work_port_q, work_port_d;
  logic                 desc_ready_q, desc_ready_d;
  logic                 learn_en_q, learn_en_d;
  logic [47:0]          learn_addr_q, learn_addr_d;
  logic [PW-1:0]        learn_port_q, learn_port_d;
  logic                 lookup_req_q, lookup_req_d;
  logic [47:0]          lookup_addr_q, lookup_addr_d;
  logic [NUM_PORTS-1:0] write_reqs_q, write_reqs_d;
  logic [PTR_W-1:0]     start_ptr_q, start_ptr_d;
  logic                 fanout_valid_q, fanout_valid_d;
  logic [FW-1:0]        fanout_q, fanout_d;
  logic [15:0]          flood_cnt_q, flood_cnt_d;
  logic [15:0]          filter_cnt_q, filter_cnt_d;

  logic                 push_c, pop_c;
  logic                 decide_c, flood_c, filter_c;
  logic [NUM_PORTS-1:0] mask_c;
  logic [PW-1:0]        dec_port_c;
  logic [PTR_W-1:0]     dec_ptr_c;
  logic [PTR_W-1:0]     head_ptr_c;
  logic [47:0]          head_da_c, head_sa_c;
  logic [PW-1:0]        head_port_c;

  function automatic logic [FW-1:0] popcount(input logic [NUM_PORTS-1:0] m);
    logic [FW-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_PORTS; i++) n = n + FW'(m[i]);
    return n;
  endfunction

  assign head_ptr_c  = fifo_ptr_q[rd_idx_q];
  assign head_da_c   = fifo_da_q[rd_idx_q];
  assign head_sa_c   = fifo_sa_q[rd_idx_q];
  assign head_port_c = fifo_port_q[rd_idx_q];

  // Next-state, FIFO bookkeeping and forwarding decision.
  always_comb begin
    state_d        = state_q;
    wr_idx_d       = wr_idx_q;
    rd_idx_d       = rd_idx_q;
    count_d        = count_q;
    timer_d        = timer_q;
    work_ptr_d     = work_ptr_q;
    work_port_d    = work_port_q;
    learn_en_d     = 1'b0;
    learn_addr_d   = learn_addr_q;
    learn_port_d   = learn_port_q;
    lookup_req_d   = 1'b0;
    lookup_addr_d  = lookup_addr_q;
    write_reqs_d   = write_reqs_q;
    start_ptr_d    = start_ptr_q;
    fanout_valid_d = 1'b0;
    fanout_d       = '0;
    flood_cnt_d    = flood_cnt_q;
    filter_cnt_d   = filter_cnt_q;
    decide_c       = 1'b0;
    flood_c        = 1'b0;
    filter_c       = 1'b0;
    mask_c         = '0;

    push_c     = desc_valid_i && desc_ready_q;
    pop_c      = (state_q == S_IDLE) && (count_q != '0);
    dec_port_c = (state_q == S_IDLE) ? head_port_c : work_port_q;
    dec_ptr_c  = (state_q == S_IDLE) ? head_ptr_c : work_ptr_q;

    if (push_c) wr_idx_d = wr_idx_q + AW'(1);
    if (pop_c)  rd_idx_d = rd_idx_q + AW'(1);
    count_d      = count_q + CW'(push_c) - CW'(pop_c);
    desc_ready_d = (count_d != CW'(FIFO_DEPTH));

    case (state_q)
      S_IDLE: begin
        if (pop_c) begin
          work_ptr_d    = head_ptr_c;
          work_port_d   = head_port_c;
          learn_en_d    = !head_sa_c[40];
          learn_addr_d  = head_sa_c;
          learn_port_d  = head_port_c;
          lookup_addr_d = head_da_c;
          timer_d       = '0;
          if (head_da_c[40]) begin
            decide_c = 1'b1;
            flood_c  = 1'b1;
          end else begin
            lookup_req_d = 1'b1;
            state_d      = S_LOOKUP;
          end
        end
      end
      S_LOOKUP: begin
        // The response is not accepted in the same cycle the request is presented.
        if (lookup_valid_i && !lookup_req_q) begin
          decide_c = 1'b1;
          if (lookup_hit_i && (lookup_port_i != work_port_q)) begin
            mask_c = NUM_PORTS'(1) << lookup_port_i;
          end else if (lookup_hit_i) begin
            filter_c = 1'b1;
          end else begin
            flood_c = 1'b1;
          end
        end else if (timer_q == TW'(LOOKUP_TIMEOUT - 1)) begin
          decide_c = 1'b1;
          flood_c  = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DISPATCH: begin
        write_reqs_d = write_reqs_q & ~write_ack_i;
        if (write_reqs_d == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flood_c) mask_c = ~(NUM_PORTS'(1) << dec_port_c);

    if (decide_c) begin
      fanout_valid_d = 1'b1;
      fanout_d       = popcount(mask_c);
      if (filter_c) begin
        state_d = S_IDLE;
        if (filter_cnt_q != CNT_MAX) filter_cnt_d = filter_cnt_q + 16'd1;
      end else begin
        state_d      = S_DISPATCH;
        write_reqs_d = mask_c;
        start_ptr_d  = dec_ptr_c;
        if (flood_c && (flood_cnt_q != CNT_MAX)) flood_cnt_d = flood_cnt_q + 16'd1;
      end
    end
  end

  // Descriptor storage; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_ptr_q[wr_idx_q]  <= start_ptr_i;
      fifo_da_q[wr_idx_q]   <= dest_addr_i;
      fifo_sa_q[wr_idx_q]   <= src_addr_i;
      fifo_port_q[wr_idx_q] <= src_port_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      wr_idx_q       <= '0;
      rd_idx_q       <= '0;
      count_q        <= '0;
      timer_q        <= '0;
      work_ptr_q     <= '0;
      work_port_q    <= '0;
      desc_ready_q   <= 1'b1;
      learn_en_q     <= 1'b0;
      learn_addr_q   <= '0;
      learn_port_q   <= '0;
      lookup_req_q   <= 1'b0;
      lookup_addr_q  <= '0;
      write_reqs_q   <= '0;
      start_ptr_q    <= '0;
      fanout_valid_q <= 1'b0;
      fanout_q       <= '0;
      flood_cnt_q    <= '0;
      filter_cnt_q   <= '0;
    end else begin
      state_q        <= state_d;
      wr_idx_q       <= wr_idx_d;
      rd_idx_q       <= rd_idx_d;
      count_q        <= count_d;
      timer_q        <= timer_d;
      work_ptr_q     <= work_ptr_d;
      work_port_q    <= work_port_d;
      desc_ready_q   <= desc_ready_d;
      learn_en_q     <= learn_en_d;
      learn_addr_q   <= learn_addr_d;
      learn_port_q   <= learn_port_d;
      lookup_req_q   <= lookup_req_d;
      lookup_addr_q  <= lookup_addr_d;
      write_reqs_q   <= write_reqs_d;
      start_ptr_q    <= start_ptr_d;
      fanout_valid_q <= fanout_valid_d;
      fanout_q       <= fanout_d;
      flood_cnt_q    <= flood_cnt_d;
      filter_cnt_q   <= filter_cnt_d;
    end
  end

  assign desc_ready_o   = desc_ready_q;
  assign learn_en_o     = learn_en_q;
  assign learn_addr_o   = learn_addr_q;
  assign learn_port_o   = learn_port_q;
  assign lookup_req_o   = lookup_req_q;
  assign lookup_addr_o  = lookup_addr_q;
  assign write_reqs_o   = write_reqs_q;
  assign start_ptr_o    = start_ptr_q;
  assign fanout_valid_o = fanout_valid_q;
  assign fanout_o       = fanout_q;
  assign flood_cnt_o    = flood_cnt_q;
  assign filter_cnt_o   = filter_cnt_q;

endmodule

// File: tb/tb_forward_engine.sv
// Bench for forward_engine: scenario tasks plus a decision scoreboard checked on fanout_valid_o.
module tb_forward_engine;

  localparam int unsigned NP    = 4;
  localparam int unsigned PW    = 2;
  localparam int unsigned PTR_W = mem_pkg::ADDR_W;

  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SA_U  = 48'h02AA_BBCC_DD01;
  localparam logic [47:0] SA_G  = 48'h0100_0000_0001;

  logic            clk = 1'b0;
  logic            rst;
  logic            desc_valid_i;
  logic            desc_ready_o;
  logic [PTR_W-1:0] start_ptr_i;
  logic [47:0]     dest_addr_i;
  logic [47:0]     src_addr_i;
  logic [PW-1:0]   src_port_i;
  logic            learn_en_o;
  logic [47:0]     learn_addr_o;
  logic [PW-1:0]   learn_port_o;
  logic            lookup_req_o;
  logic [47:0]     lookup_addr_o;
  logic            lookup_valid_i;
  logic            lookup_hit_i;
  logic [PW-1:0]   lookup_port_i;
  logic [NP-1:0]   write_reqs_o;
  logic [PTR_W-1:0] start_ptr_o;
  logic [NP-1:0]   write_ack_i;
  logic            fanout_valid_o;
  logic [PW:0]     fanout_o;
  logic [15:0]     flood_cnt_o;
  logic [15:0]     filter_cnt_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [NP-1:0]    mask;
    logic [PTR_W-1:0] ptr;
    logic [PW:0]      fanout;
  } exp_t;

  exp_t sb_q[$];

  forward_engine #(
    .NUM_PORTS(NP), .PTR_W(PTR_W), .FIFO_DEPTH(4), .LOOKUP_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
    .start_ptr_i(start_ptr_i), .dest_addr_i(dest_addr_i),
    .src_addr_i(src_addr_i), .src_port_i(src_port_i),
    .learn_en_o(learn_en_o), .learn_addr_o(learn_addr_o), .learn_port_o(learn_port_o),
    .lookup_req_o(lookup_req_o), .lookup_addr_o(lookup_addr_o),
    .lookup_valid_i(lookup_valid_i), .lookup_hit_i(lookup_hit_i), .lookup_port_i(lookup_port_i),
    .write_reqs_o(write_reqs_o), .start_ptr_o(start_ptr_o), .write_ack_i(write_ack_i),
    .fanout_valid_o(fanout_valid_o), .fanout_o(fanout_o),
    .flood_cnt_o(flood_cnt_o), .filter_cnt_o(filter_cnt_o)
  );

  always #5 clk = ~clk;

  // Scoreboard: each decision pulse is matched against the oldest expected entry.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && fanout_valid_o) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_decision fanout=%0d mask=%b", fanout_o, write_reqs_o);
      end else begin
        e = sb_q.pop_front();
        if (fanout_o !== e.fanout) begin
          errors++;
          $display("FAIL sb_fanout got=%0d exp=%0d", fanout_o, e.fanout);
        end
        if (e.mask != '0) begin
          checks++;
          if (write_reqs_o !== e.mask || start_ptr_o !== e.ptr) begin
            errors++;
            $display("FAIL sb_dispatch got mask=%b ptr=%h exp mask=%b ptr=%h",
                     write_reqs_o, start_ptr_o, e.mask, e.ptr);
          end
        end
      end
    end
  end

  task automatic send_desc(input logic [PTR_W-1:0] ptr, input logic [47:0] da,
                           input logic [47:0] sa, input logic [PW-1:0] port,
                           input logic [NP-1:0] exp_mask, input logic [PW:0] exp_fan,
                           input bit track);
    int n;
    exp_t e;
    n = 0;
    desc_valid_i = 1'b1;
    start_ptr_i  = ptr;
    dest_addr_i  = da;
    src_addr_i   = sa;
    src_port_i   = port;
    while (!desc_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (desc_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL desc_accept ready=%b exp=1", desc_ready_o);
    end else if (track) begin
      e.mask = exp_mask; e.ptr = ptr; e.fanout = exp_fan;
      sb_q.push_back(e);
    end
    @(negedge clk);
    desc_valid_i = 1'b0;
  endtask

  task automatic wait_lookup_req(output bit ok);
    int n;
    n = 0;
    while (!lookup_req_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    ok = lookup_req_o;
  endtask

  task automatic wait_fanout(output bit ok);
    int n;
    n = 0;
    while (!fanout_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = fanout_valid_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (desc_ready_o !== 1'b1 || write_reqs_o !== '0 || fanout_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl ready=%b reqs=%b fv=%b exp 1/0000/0",
               desc_ready_o, write_reqs_o, fanout_valid_o);
    end
    checks++;
    if (learn_en_o !== 1'b0 || lookup_req_o !== 1'b0 || flood_cnt_o !== 16'd0 ||
        filter_cnt_o !== 16'd0 || start_ptr_o !== '0 || fanout_o !== '0) begin
      errors++;
      $display("FAIL reset_outs learn=%b req=%b flood=%0d filter=%0d ptr=%h fan=%0d exp all 0",
               learn_en_o, lookup_req_o, flood_cnt_o, filter_cnt_o, start_ptr_o, fanout_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unicast_hit();
    bit ok;
    send_desc(12'h0A1, 48'h0011_2233_4455, SA_U, 2'd0, 4'b0100, 3'd1, 1'b1);
    wait_lookup_req(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL hit_lookup_req got=0 exp=1");
    end
    checks++;
    if (learn_en_o !== 1'b1 || learn_addr_o !== SA_U || learn_port_o !== 2'd0) begin
      errors++;
      $display("FAIL hit_learn en=%b addr=%h port=%0d exp 1/%h/0", learn_en_o, learn_addr_o,
               learn_port_o, SA_U);
    end
    checks++;
    if (lookup_addr_o !== 48'h0011_2233_4455) begin
      errors++;
      $display("FAIL hit_lookup_addr got=%h exp=001122334455", lookup_addr_o);
    end
    @(negedge clk);
    checks++;
    if (learn_en_o !== 1'b0 || lookup_req_o !== 1'b0) begin
      errors++;
      $display("FAIL hit_pulse_width learn=%b req=%b exp 0/0", learn_en_o, lookup_req_o);
    end
    lookup_valid_i = 1'b1; lookup_hit_i = 1'b1; lookup_port_i = 2'd2;
    @(negedge clk);
    lookup_valid_i = 1'b0; lookup_hit_i = 1'b0; lookup_port_i = 2'd0;
    checks++;
    if (write_reqs_o !== 4'b0100) begin
      errors++;
      $display("FAIL hit_write_reqs got=%b exp=0100", write_reqs_o);
    end
    write_ack_i = 4'b0100;
    @(negedge clk);
    write_ack_i = '0;
    checks++;
    if (write_reqs_o !== 4'b0000) begin
      errors++;
      $display("FAIL hit_ack_clear got=%b exp=0000", write_reqs_o);
    end
  endtask

  task automatic test_broadcast();
    bit ok;
    send_desc(12'h0B2, BCAST, SA_U, 2'd1, 4'b1101, 3'd3, 1'b1);
    wait_fanout(ok);
    checks++;
    if (!ok || lookup_req_o !== 1'b0 || learn_en_o !== 1'b1 || write_reqs_o !== 4'b1101) begin
      errors++;
      $display("FAIL bcast_issue fv=%b req=%b learn=%b reqs=%b exp 1/0/1/1101",
               ok, lookup_req_o, learn_en_o, write_reqs_o);
    end
    write_ack_i = 4'b0011;
    @(negedge clk);
    checks++;
    if (write_reqs_o !== 4'b1100) begin
      errors++;
      $display("FAIL bcast_ack0 got=%b exp=1100", write_reqs_o);
    end
    write_ack_i = 4'b0100;
    @(negedge clk);
    write_ack_i = '0;
    checks++;
    if (write_reqs_o !== 4'b1000) begin
      errors++;
      $display("FAIL bcast_ack2 got=%b exp=1000", write_reqs_o);
    end
    @(negedge clk);
    checks++;
    if (write_reqs_o !== 4'b1000) begin
      errors++;
      $display("FAIL bcast_hold got=%b exp=1000", write_reqs_o);
    end
    write_ack_i = 4'b1000;
    @(negedge clk);
    write_ack_i = '0;
    checks++;
    if (write_reqs_o !== 4'b0000 || flood_cnt_o !== 16'd1) begin
      errors++;
      $display("FAIL bcast_done reqs=%b flood=%0d exp 0000/1", write_reqs_o, flood_cnt_o);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    bit early;
    send_desc(12'h0C3, 48'h0A0B_0C0D_0E0F, SA_U, 2'd0, 4'b1110, 3'd3, 1'b1);
    wait_lookup_req(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL tmo_lookup_req got=0 exp=1");
    end
    early = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (write_reqs_o !== '0 || fanout_valid_o !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL tmo_early got=decision_before_8 exp=none");
    end
    @(negedge clk);
    checks++;
    if (write_reqs_o !== 4'b1110 || fanout_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL tmo_flood reqs=%b fv=%b exp 1110/1", write_reqs_o, fanout_valid_o);
    end
    write_ack_i = 4'b1110;
    @(negedge clk);
    write_ack_i = '0;
    checks++;
    if (write_reqs_o !== 4'b0000 || flood_cnt_o !== 16'd2) begin
      errors++;
      $display("FAIL tmo_done reqs=%b flood=%0d exp 0000/2", write_reqs_o, flood_cnt_o);
    end
  endtask

  task automatic test_filter();
    bit ok;
    send_desc(12'h0D4, 48'h0033_4455_6677, SA_G, 2'd3, 4'b0000, 3'd0, 1'b1);
    wait_lookup_req(ok);
    checks++;
    if (!ok || learn_en_o !== 1'b0) begin
      errors++;
      $display("FAIL filt_req_nolearn req=%b learn=%b exp 1/0", ok, learn_en_o);
    end
    @(negedge clk);
    lookup_valid_i = 1'b1; lookup_hit_i = 1'b1; lookup_port_i = 2'd3;
    @(negedge clk);
    lookup_valid_i = 1'b0; lookup_hit_i = 1'b0; lookup_port_i = 2'd0;
    checks++;
    if (fanout_valid_o !== 1'b1 || write_reqs_o !== '0 || filter_cnt_o !== 16'd1) begin
      errors++;
      $display("FAIL filt_decision fv=%b reqs=%b filter=%0d exp 1/0000/1",
               fanout_valid_o, write_reqs_o, filter_cnt_o);
    end
    @(negedge clk);
    checks++;
    if (write_reqs_o !== '0 || flood_cnt_o !== 16'd2) begin
      errors++;
      $display("FAIL filt_after reqs=%b flood=%0d exp 0000/2", write_reqs_o, flood_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [NP-1:0] m;
    for (int i = 0; i < 5; i++) begin
      m = 4'b0001 << (i % 4);
      send_desc(PTR_W'(32'h100 + i), BCAST, SA_U, PW'(i % 4), ~m, 3'd3, 1'b1);
    end
    checks++;
    if (desc_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_full got=%b exp=0", desc_ready_o);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (desc_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold got=%b exp=0", desc_ready_o);
    end
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (write_reqs_o == '0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (write_reqs_o == '0) begin
        errors++;
        $display("FAIL bp_dispatch_%0d got=none exp=dispatch", k);
      end
      write_ack_i = '1;
      @(negedge clk);
      write_ack_i = '0;
    end
    checks++;
    if (desc_ready_o !== 1'b1 || write_reqs_o !== '0 || flood_cnt_o !== 16'd7) begin
      errors++;
      $display("FAIL bp_drain ready=%b reqs=%b flood=%0d exp 1/0000/7",
               desc_ready_o, write_reqs_o, flood_cnt_o);
    end
  endtask

  task automatic test_reset_mid_dispatch();
    bit ok;
    bit stray;
    send_desc(12'h0E5, BCAST, SA_U, 2'd0, 4'b1110, 3'd3, 1'b1);
    wait_fanout(ok);
    write_ack_i = 4'b1000;
    @(negedge clk);
    write_ack_i = '0;
    checks++;
    if (write_reqs_o !== 4'b0110) begin
      errors++;
      $display("FAIL rstmid_pre got=%b exp=0110", write_reqs_o);
    end
    send_desc(12'h0F6, BCAST, SA_U, 2'd1, 4'b1101, 3'd3, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (write_reqs_o !== '0 || desc_ready_o !== 1'b1 || flood_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_clear reqs=%b ready=%b flood=%0d exp 0000/1/0",
               write_reqs_o, desc_ready_o, flood_cnt_o);
    end
    rst = 1'b0;
    lookup_valid_i = 1'b1; lookup_hit_i = 1'b1; lookup_port_i = 2'd1;
    @(negedge clk);
    lookup_valid_i = 1'b0; lookup_hit_i = 1'b0; lookup_port_i = 2'd0;
    stray = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (write_reqs_o !== '0 || fanout_valid_o !== 1'b0 || lookup_req_o !== 1'b0 ||
          learn_en_o !== 1'b0) stray = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL rstmid_quiet got=activity exp=idle");
    end
  endtask

  initial begin
    rst            = 1'b1;
    desc_valid_i   = 1'b0;
    start_ptr_i    = '0;
    dest_addr_i    = '0;
    src_addr_i     = '0;
    src_port_i     = '0;
    lookup_valid_i = 1'b0;
    lookup_hit_i   = 1'b0;
    lookup_port_i  = '0;
    write_ack_i    = '0;

    test_reset();
    test_unicast_hit();
    test_broadcast();
    test_timeout();
    test_filter();
    test_back_to_back();
    test_reset_mid_dispatch();

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d exp=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
